// File: rtl/icg_pkg.sv
// icg_pkg: shared types and helpers for the clock-gated register bank.
//   icg_state_t  per-channel gate state (OPEN / HOLD / CLOSED)
//   clog2_min1   bit width for a counter holding values 0..n-1, never below 1
package icg_pkg;

  typedef enum logic [1:0] {
    ST_OPEN,
    ST_HOLD,
    ST_CLOSED
  } icg_state_t;

  // Width needed for the hold-off counter, which holds 0..n-1.
  // n = 0, 1 or 2 still yields one bit, so the counter never has zero width.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/icg_cell.sv
// icg_cell: behavioural integrated clock gate. This model is used for
// simulation. Synthesis replaces it with the library ICG cell.
//   clk      free-running clock
//   en       functional gate enable
//   test_en  scan override, forces the gate open
//   gclk     gated clock
// The enable is captured by a latch that is transparent while clk is low.
// The latched value can therefore change only during the low phase, which
// keeps gclk glitch-free.
module icg_cell (
  input  logic clk,
  input  logic en,
  input  logic test_en,
  output logic gclk
);

  logic en_lat;

  // NOTE: always_latch makes the storage intentional. This latch is the
  // gating element, not a missing else-branch in combinational code.
  always_latch begin
    if (!clk) en_lat <= en | test_en;
  end

  assign gclk = clk & en_lat;

endmodule

// File: rtl/icg_reg_bank.sv
// icg_reg_bank: CHANNELS independent WIDTH-bit registers. Each register sits
// behind its own clock gate. A per-channel hold-off FSM keeps the gate open
// for HOLD_CYCLES after the enable drops, so the gate does not toggle on
// bursty enables. A shared saturating counter records cycles in which every
// channel is gated.
//   clk           free-running clock
//   reset         synchronous, active-high reset
//   en            per-channel load enable
//   test_en       scan override, forces every gate open
//   clr_cnt       synchronous clear of gated_cycles
//   d             packed data in, channel i at [i*WIDTH +: WIDTH]
//   q             packed registered data, same layout as d
//   gated         1 = channel gate closed (state CLOSED)
//   gated_cycles  saturating count of all-CLOSED cycles
module icg_reg_bank
  import icg_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 3,
  parameter int COUNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       en,
  input  logic                      test_en,
  input  logic                      clr_cnt,
  input  logic [CHANNELS*WIDTH-1:0] d,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       gated,
  output logic [COUNT_W-1:0]        gated_cycles
);

  localparam int HW = clog2_min1(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_INIT =
    (HOLD_CYCLES == 0) ? '0 : HW'(HOLD_CYCLES - 1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    icg_state_t        state, state_nxt;
    logic [HW-1:0]     hold_cnt, hold_cnt_nxt;
    logic              gate_en;
    logic              gclk;
    logic [WIDTH-1:0]  q_r;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      if (en[i]) begin
        state_nxt = ST_OPEN;
      end else begin
        unique case (state)
          ST_OPEN: begin
            if (HOLD_CYCLES == 0) begin
              state_nxt = ST_CLOSED;
            end else begin
              state_nxt    = ST_HOLD;
              hold_cnt_nxt = HOLD_INIT;
            end
          end
          ST_HOLD: begin
            if (hold_cnt == '0) state_nxt = ST_CLOSED;
            else                hold_cnt_nxt = hold_cnt - HW'(1);
          end
          ST_CLOSED: state_nxt = ST_CLOSED;
          default:   state_nxt = ST_CLOSED;
        endcase
      end
    end

    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then sample pre-edge values, whatever the process evaluation order.
    always_ff @(posedge clk) begin
      if (reset) begin
        state    <= ST_CLOSED;
        hold_cnt <= '0;
      end else begin
        state    <= state_nxt;
        hold_cnt <= hold_cnt_nxt;
      end
    end

    // en[i] is included directly so the load edge is not lost on the cycle
    // that leaves CLOSED. reset is included so the gated flop sees the reset edge.
    assign gate_en = en[i] | (state != ST_CLOSED) | reset;

    icg_cell u_icg (
      .clk     (clk),
      .en      (gate_en),
      .test_en (test_en),
      .gclk    (gclk)
    );

    // NOTE: the data register is an ordinary resettable flop, not a memory.
    // Its synchronous reset takes effect only because gate_en forces the
    // gate open while reset is high.
    always_ff @(posedge gclk) begin
      if (reset)      q_r <= '0;
      else if (en[i]) q_r <= d[i*WIDTH +: WIDTH];
    end

    assign q[i*WIDTH +: WIDTH] = q_r;
    assign gated[i]            = (state == ST_CLOSED);
  end

  // gated is a registered state decode, so this counter lags it by one cycle.
  always_ff @(posedge clk) begin
    if (reset || clr_cnt) begin
      gated_cycles <= '0;
    end else if ((&gated) && (gated_cycles != '1)) begin
      gated_cycles <= gated_cycles + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_icg_reg_bank.sv
// tb_icg_reg_bank: table-driven self-checking bench for icg_reg_bank
// (CHANNELS=2, WIDTH=8, HOLD_CYCLES=3, COUNT_W=8). The bench drives inputs
// on the falling edge and queues the expected post-edge values. It pops and
// compares them 1 ns after the rising edge.
module tb_icg_reg_bank;

  logic        clk;
  logic        reset;
  logic [1:0]  en;
  logic        test_en;
  logic        clr_cnt;
  logic [15:0] d;
  logic [15:0] q;
  logic [1:0]  gated;
  logic [7:0]  gated_cycles;

  int n_checks = 0;
  int n_errors = 0;

  icg_reg_bank #(
    .CHANNELS    (2),
    .WIDTH       (8),
    .HOLD_CYCLES (3),
    .COUNT_W     (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .test_en      (test_en),
    .clr_cnt      (clr_cnt),
    .d            (d),
    .q            (q),
    .gated        (gated),
    .gated_cycles (gated_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  en;
    logic        test_en;
    logic        clr;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [15:0] q;      // {q1, q0}
    logic [1:0]  gated;
    logic [1:0]  gclk;   // gated clocks while clk is high, just after the edge
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(input logic rst, input logic [1:0] en_v,
                              input logic te, input logic clr,
                              input logic [7:0] d0, input logic [7:0] d1,
                              input logic [15:0] eq, input logic [1:0] eg,
                              input logic [1:0] eclk, input logic [7:0] ecnt);
    vec_t v;
    v.rst = rst; v.en = en_v; v.test_en = te; v.clr = clr;
    v.d0 = d0; v.d1 = d1; v.q = eq; v.gated = eg; v.gclk = eclk; v.cnt = ecnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    reset   = v.rst;
    en      = v.en;
    test_en = v.test_en;
    clr_cnt = v.clr;
    d       = {v.d1, v.d0};
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, " q"},     q, e.q);
    check({tag, " gated"}, {14'd0, gated}, {14'd0, e.gated});
    check({tag, " gclk"},  {14'd0, dut.g_ch[1].gclk, dut.g_ch[0].gclk},
                           {14'd0, e.gclk});
    check({tag, " cnt"},   {8'd0, gated_cycles}, {8'd0, e.cnt});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    logic [7:0] exp_cnt;

    reset = 1'b1; en = 2'b11; test_en = 1'b0; clr_cnt = 1'b0; d = 16'hFFFF;

    //                rst en    te clr d0     d1     q         gated  gclk   cnt
    // Reset: two cycles with en=11 and d=FF. The first cycle after reset counts.
    tbl.push_back(mk(1, 2'b11, 0, 0, 8'hFF, 8'hFF, 16'h0000, 2'b11, 2'b11, 8'd0));
    tbl.push_back(mk(1, 2'b11, 0, 0, 8'hFF, 8'hFF, 16'h0000, 2'b11, 2'b11, 8'd0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 8'h00, 8'h00, 16'h0000, 2'b11, 2'b00, 8'd1));
    // ch0: one-cycle load of A5, then hold through HOLD. gated[0] rises 4 edges later.
    tbl.push_back(mk(0, 2'b01, 0, 0, 8'hA5, 8'h00, 16'h00A5, 2'b10, 2'b01, 8'd2));
    tbl.push_back(mk(0, 2'b00, 0, 0, 8'h3C, 8'h00, 16'h00A5, 2'b10, 2'b01, 8'd2));
    tbl.push_back(mk(0, 2'b00, 0, 0, 8'h3C, 8'h00, 16'h00A5, 2'b10, 2'b01, 8'd2));
    tbl.push_back(mk(0, 2'b00, 0, 0, 8'h3C, 8'h00, 16'h00A5, 2'b10, 2'b01, 8'd2));
    tbl.push_back(mk(0, 2'b00, 0, 0, 8'h3C, 8'h00, 16'h00A5, 2'b11, 2'b01, 8'd2));
    tbl.push_back(mk(0, 2'b00, 0, 0, 8'h3C, 8'h00, 16'h00A5, 2'b11, 2'b00, 8'd3));
    // ch1: pulse 1-0-0-1. The re-enable lands mid-HOLD, so gated[1] stays low.
    tbl.push_back(mk(0, 2'b10, 0, 0, 8'h00, 8'h11, 16'h11A5, 2'b01, 2'b10, 8'd4));
    tbl.push_back(mk(0, 2'b00, 0, 0, 8'h00, 8'h55, 16'h11A5, 2'b01, 2'b10, 8'd4));
    tbl.push_back(mk(0, 2'b00, 0, 0, 8'h00, 8'h55, 16'h11A5, 2'b01, 2'b10, 8'd4));
    tbl.push_back(mk(0, 2'b10, 0, 0, 8'h00, 8'h22, 16'h22A5, 2'b01, 2'b10, 8'd4));
    tbl.push_back(mk(0, 2'b00, 0, 0, 8'h00, 8'h99, 16'h22A5, 2'b01, 2'b10, 8'd4));
    tbl.push_back(mk(0, 2'b00, 0, 0, 8'h00, 8'h99, 16'h22A5, 2'b01, 2'b10, 8'd4));
    tbl.push_back(mk(0, 2'b00, 0, 0, 8'h00, 8'h99, 16'h22A5, 2'b01, 2'b10, 8'd4));
    tbl.push_back(mk(0, 2'b00, 0, 0, 8'h00, 8'h99, 16'h22A5, 2'b11, 2'b10, 8'd4));
    tbl.push_back(mk(0, 2'b00, 0, 0, 8'h00, 8'h99, 16'h22A5, 2'b11, 2'b00, 8'd5));
    // Reset asserted mid-HOLD forces CLOSED and clears q through the open gate.
    tbl.push_back(mk(0, 2'b01, 0, 0, 8'h5A, 8'h00, 16'h225A, 2'b10, 2'b01, 8'd6));
    tbl.push_back(mk(0, 2'b00, 0, 0, 8'h00, 8'h00, 16'h225A, 2'b10, 2'b01, 8'd6));
    tbl.push_back(mk(1, 2'b00, 0, 0, 8'h00, 8'h00, 16'h0000, 2'b11, 2'b11, 8'd0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 8'h00, 8'h00, 16'h0000, 2'b11, 2'b00, 8'd1));
    // clr_cnt arrives together with the increment condition, and clear wins.
    tbl.push_back(mk(0, 2'b00, 0, 1, 8'h00, 8'h00, 16'h0000, 2'b11, 2'b00, 8'd0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 8'h00, 8'h00, 16'h0000, 2'b11, 2'b00, 8'd1));
    // test_en opens every gate, while q and gated stay unchanged.
    tbl.push_back(mk(0, 2'b00, 1, 0, 8'h77, 8'h77, 16'h0000, 2'b11, 2'b11, 8'd2));
    tbl.push_back(mk(0, 2'b00, 0, 0, 8'h77, 8'h77, 16'h0000, 2'b11, 2'b00, 8'd3));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Both channels CLOSED for 300 cycles: the counter must saturate at FF.
    exp_cnt = 8'd3;
    for (int k = 0; k < 300; k++) begin
      exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
      v = mk(0, 2'b00, 0, 0, 8'h00, 8'h00, 16'h0000, 2'b11, 2'b00, exp_cnt);
      apply(v, $sformatf("sat%0d", k));
    end
    check("saturated", {8'd0, gated_cycles}, 16'h00FF);

    // A clr_cnt pulse returns the counter to 0, and counting then resumes.
    apply(mk(0, 2'b00, 0, 1, 8'h00, 8'h00, 16'h0000, 2'b11, 2'b00, 8'd0), "clr");
    for (int k = 1; k <= 3; k++) begin
      v = mk(0, 2'b00, 0, 0, 8'h00, 8'h00, 16'h0000, 2'b11, 2'b00, 8'(k));
      apply(v, $sformatf("resume%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
